// File: rtl/draw_sprite_mux_if.sv
// VGA pixel stream bundle: timing counters, sync/blank strobes and 12-bit colour.
// The master drives the stream, the slave consumes it.
interface draw_sprite_mux_if;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite_mux.sv
// Multi-sprite compositor: overlays N_SPR ROM-backed sprites onto a VGA stream with fixed
// index priority and colour-key transparency. Latency is ROM_LAT+2 clocks.
module draw_sprite_mux #(
    parameter int unsigned N_SPR   = 4,
    parameter int unsigned SPR_W   = 48,
    parameter int unsigned SPR_H   = 64,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned ROM_LAT = 1,
    parameter logic [11:0] KEY_RGB = 12'hF0F
) (
    input  logic                         clk,
    input  logic                         rst,
    draw_sprite_mux_if.slave             in,
    draw_sprite_mux_if.master            out,
    input  logic [N_SPR-1:0][11:0]       spr_xpos,
    input  logic [N_SPR-1:0][11:0]       spr_ypos,
    input  logic [N_SPR-1:0]             spr_en,
    output logic [N_SPR-1:0][ADDR_W-1:0] pixel_addr,
    input  logic [N_SPR-1:0][11:0]       rgb_pixel
);

    if (SPR_W * SPR_H > 2 ** ADDR_W) begin : g_chk_addr
        $error("draw_sprite_mux: SPR_W*SPR_H does not fit in ADDR_W address bits");
    end
    if (N_SPR < 1 || N_SPR > 8) begin : g_chk_nspr
        $error("draw_sprite_mux: N_SPR must be 1..8");
    end
    if (ROM_LAT > 3) begin : g_chk_lat
        $error("draw_sprite_mux: ROM_LAT must be 0..3");
    end

    typedef struct packed {
        logic [11:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } pix_t;

    // 13-bit compare so a sprite near 4095 cannot wrap onto low coordinates.
    function automatic logic in_range(input logic [11:0] v, input logic [11:0] lo,
                                      input int unsigned size);
        logic [12:0] v13, lo13, hi13;
        v13  = {1'b0, v};
        lo13 = {1'b0, lo};
        hi13 = lo13 + 13'(size - 1);
        return (v13 >= lo13) && (v13 <= hi13);
    endfunction

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [11:0] dy, input logic [11:0] dx);
        logic [31:0] lin;
        lin = 32'(dy) * SPR_W + 32'(dx);
        return lin[ADDR_W-1:0];
    endfunction

    // Frame-start shadow registers
    logic                   vsync_d;
    logic [N_SPR-1:0][11:0] xs_q, ys_q;
    logic [N_SPR-1:0]       en_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            xs_q    <= '0;
            ys_q    <= '0;
            en_s_q  <= '0;
        end else begin
            vsync_d <= in.vsync;
            if (in.vsync && !vsync_d) begin
                xs_q   <= spr_xpos;
                ys_q   <= spr_ypos;
                en_s_q <= spr_en;
            end
        end
    end

    // Stage 1: hit test and ROM address
    logic [N_SPR-1:0]             hit;
    logic [N_SPR-1:0][ADDR_W-1:0] addr_d;
    logic [N_SPR-1:0][ADDR_W-1:0] addr_q;
    logic [N_SPR-1:0]             hit1_q;

    always_comb begin
        hit    = '0;
        addr_d = '0;
        for (int i = 0; i < int'(N_SPR); i++) begin
            hit[i] = en_s_q[i] && !in.hblnk && !in.vblnk &&
                     in_range(in.hcount, xs_q[i], SPR_W) &&
                     in_range(in.vcount, ys_q[i], SPR_H);
            if (hit[i]) begin
                addr_d[i] = lin_addr(in.vcount - ys_q[i], in.hcount - xs_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            hit1_q <= '0;
        end else begin
            addr_q <= addr_d;
            hit1_q <= hit;
        end
    end

    assign pixel_addr = addr_q;

    // Align hit flags with ROM data
    logic [N_SPR-1:0] hit_r;

    if (ROM_LAT == 0) begin : g_no_lat
        assign hit_r = hit1_q;
    end else begin : g_lat
        logic [N_SPR-1:0] hit_pipe_q [ROM_LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hit_pipe_q <= '{default: '0};
            end else begin
                hit_pipe_q[0] <= hit1_q;
                for (int unsigned k = 1; k < ROM_LAT; k++) begin
                    hit_pipe_q[k] <= hit_pipe_q[k-1];
                end
            end
        end

        assign hit_r = hit_pipe_q[ROM_LAT-1];
    end

    // Pass-through delay line; the final stage is the compose register
    pix_t in_pix;
    pix_t dly_q [ROM_LAT+1];
    pix_t comp;
    pix_t out_q;

    assign in_pix = '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk,
                      hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk, rgb: in.rgb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= '{default: '0};
        end else begin
            dly_q[0] <= in_pix;
            for (int unsigned k = 1; k <= ROM_LAT; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end
    end

    // Walk from highest to lowest index so the lowest visible sprite wins.
    always_comb begin
        comp = dly_q[ROM_LAT];
        for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
            if (hit_r[i] && (rgb_pixel[i] != KEY_RGB)) begin
                comp.rgb = rgb_pixel[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= comp;
        end
    end

    assign out.vcount = out_q.vcount;
    assign out.vsync  = out_q.vsync;
    assign out.vblnk  = out_q.vblnk;
    assign out.hcount = out_q.hcount;
    assign out.hsync  = out_q.hsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite_mux.sv
// Directed bench for draw_sprite_mux: a table of held pixels plus exact-latency, frame-latch,
// same-cycle capture and async-reset sequences across three parameter sets.
module tb_draw_sprite_mux;

    logic clk = 1'b0;
    logic rst = 1'b0;
    initial forever #5 clk = ~clk;

    logic [7:0][11:0] xpos, ypos;
    logic [7:0]       en;
    int               rom_mode;

    logic [3:0][11:0] addr_m, rgb_m;
    logic [0:0][11:0] addr_a, rgb_a;
    logic [7:0][11:0] addr_b, addr_b1, addr_b2, rgb_b;

    draw_sprite_mux_if vin ();
    draw_sprite_mux_if vout_m ();
    draw_sprite_mux_if vout_a ();
    draw_sprite_mux_if vout_b ();

    draw_sprite_mux dut (
        .clk(clk), .rst(rst), .in(vin.slave), .out(vout_m.master),
        .spr_xpos(xpos[3:0]), .spr_ypos(ypos[3:0]), .spr_en(en[3:0]),
        .pixel_addr(addr_m), .rgb_pixel(rgb_m)
    );

    draw_sprite_mux #(.N_SPR(1), .ROM_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .in(vin.slave), .out(vout_a.master),
        .spr_xpos(xpos[0:0]), .spr_ypos(ypos[0:0]), .spr_en(en[0:0]),
        .pixel_addr(addr_a), .rgb_pixel(rgb_a)
    );

    draw_sprite_mux #(.N_SPR(8), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .in(vin.slave), .out(vout_b.master),
        .spr_xpos(xpos), .spr_ypos(ypos), .spr_en(en),
        .pixel_addr(addr_b), .rgb_pixel(rgb_b)
    );

    // Mode 0: ROM returns its address. Mode 1: sprite 0 keyed on even addresses.
    function automatic logic [11:0] rom_f(input int spr, input logic [11:0] a, input int mode);
        if (mode == 0) return a;
        if (spr == 0) return a[0] ? 12'h111 : 12'hF0F;
        return 12'h222;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) rgb_m[i] <= rom_f(i, addr_m[i], rom_mode);
        addr_b1 <= addr_b;
        addr_b2 <= addr_b1;
        for (int i = 0; i < 8; i++) rgb_b[i] <= rom_f(i, addr_b2[i], rom_mode);
    end

    always_comb rgb_a[0] = rom_f(0, addr_a[0], rom_mode);

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [11:0] hc, input logic [11:0] vc, input logic hb,
                           input logic vb, input logic hs);
        vin.hcount = hc;
        vin.vcount = vc;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hs;
        vin.rgb    = 12'hABC;
    endtask

    task automatic frame_start();
        vin.vsync = 1'b1;
        step();
        vin.vsync = 1'b0;
        step();
    endtask

    task automatic load_cfg(input int cfg);
        xpos = '0; ypos = '0; en = '0; rom_mode = 0;
        case (cfg)
            0: begin xpos[0] = 12'd100; ypos[0] = 12'd200; en = 8'h01; end
            1: begin
                xpos[0] = 12'd300; ypos[0] = 12'd300;
                xpos[1] = 12'd300; ypos[1] = 12'd300;
                en = 8'h03; rom_mode = 1;
            end
            2: begin xpos[0] = 12'd4090; ypos[0] = 12'd0; en = 8'h01; end
            default: begin xpos[0] = 12'd780; ypos[0] = 12'd0; en = 8'h01; end
        endcase
        frame_start();
    endtask

    task automatic hold_check_rgb(input string name, input logic [11:0] hc,
                                  input logic [11:0] vc, input logic [11:0] exp);
        set_pix(hc, vc, 1'b0, 1'b0, 1'b0);
        repeat (6) step();
        check(name, 32'(vout_m.rgb), 32'(exp));
    endtask

    // Single-cycle pixel with an hsync marker; measures latency and exact rgb on every DUT.
    task automatic pulse_pix(input string name, input logic [11:0] hc, input logic [11:0] vc,
                             input logic [11:0] exp_rgb, input logic [11:0] exp_addr);
        int lat_m, lat_a, lat_b;
        logic [11:0] r_m, r_a, r_b;
        lat_m = -1; lat_a = -1; lat_b = -1;
        r_m = '0; r_a = '0; r_b = '0;
        set_pix(12'd50, 12'd200, 1'b0, 1'b0, 1'b0);
        repeat (6) step();
        set_pix(hc, vc, 1'b0, 1'b0, 1'b1);
        step();
        check({name, "_addr_t1"}, 32'(addr_m[0]), 32'(exp_addr));
        set_pix(12'd50, 12'd200, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) step();
            if (vout_m.hsync && lat_m < 0) begin lat_m = c; r_m = vout_m.rgb; end
            if (vout_a.hsync && lat_a < 0) begin lat_a = c; r_a = vout_a.rgb; end
            if (vout_b.hsync && lat_b < 0) begin lat_b = c; r_b = vout_b.rgb; end
        end
        check({name, "_lat_lat1"}, 32'(lat_m), 32'd3);
        check({name, "_lat_lat0"}, 32'(lat_a), 32'd2);
        check({name, "_lat_lat3"}, 32'(lat_b), 32'd5);
        check({name, "_rgb_lat1"}, 32'(r_m), 32'(exp_rgb));
        check({name, "_rgb_lat0"}, 32'(r_a), 32'(exp_rgb));
        check({name, "_rgb_lat3"}, 32'(r_b), 32'(exp_rgb));
    endtask

    typedef struct {
        int          cfg;
        logic [11:0] hc;
        logic [11:0] vc;
        logic        hb;
        logic        vb;
        logic [11:0] exp_rgb;
        logic [11:0] exp_addr;
        logic        sweep;
    } vec_t;

    vec_t vecs [22];

    initial begin
        int cur_cfg;
        vecs[0]  = '{0, 12'd100, 12'd200, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1};
        vecs[1]  = '{0, 12'd147, 12'd263, 1'b0, 1'b0, 12'hBFF, 12'hBFF, 1'b1};
        vecs[2]  = '{0, 12'd148, 12'd200, 1'b0, 1'b0, 12'hABC, 12'h000, 1'b1};
        vecs[3]  = '{0, 12'd101, 12'd200, 1'b0, 1'b0, 12'h001, 12'h001, 1'b1};
        vecs[4]  = '{0, 12'd100, 12'd201, 1'b0, 1'b0, 12'h030, 12'h030, 1'b1};
        vecs[5]  = '{0, 12'd99,  12'd200, 1'b0, 1'b0, 12'hABC, 12'h000, 1'b1};
        vecs[6]  = '{0, 12'd120, 12'd264, 1'b0, 1'b0, 12'hABC, 12'h000, 1'b1};
        vecs[7]  = '{0, 12'd110, 12'd210, 1'b1, 1'b0, 12'hABC, 12'h000, 1'b1};
        vecs[8]  = '{0, 12'd110, 12'd210, 1'b0, 1'b1, 12'hABC, 12'h000, 1'b1};
        vecs[9]  = '{0, 12'd110, 12'd210, 1'b0, 1'b0, 12'h1EA, 12'h1EA, 1'b1};
        vecs[10] = '{1, 12'd300, 12'd300, 1'b0, 1'b0, 12'h222, 12'h000, 1'b0};
        vecs[11] = '{1, 12'd301, 12'd300, 1'b0, 1'b0, 12'h111, 12'h001, 1'b0};
        vecs[12] = '{1, 12'd302, 12'd300, 1'b0, 1'b0, 12'h222, 12'h002, 1'b0};
        vecs[13] = '{1, 12'd303, 12'd300, 1'b0, 1'b0, 12'h111, 12'h003, 1'b0};
        vecs[14] = '{1, 12'd299, 12'd300, 1'b0, 1'b0, 12'hABC, 12'h000, 1'b0};
        vecs[15] = '{1, 12'd347, 12'd300, 1'b0, 1'b0, 12'h111, 12'h02F, 1'b0};
        vecs[16] = '{2, 12'd0,   12'd0,   1'b0, 1'b0, 12'hABC, 12'h000, 1'b0};
        vecs[17] = '{2, 12'd799, 12'd0,   1'b0, 1'b0, 12'hABC, 12'h000, 1'b0};
        vecs[18] = '{2, 12'd1055, 12'd63, 1'b0, 1'b0, 12'hABC, 12'h000, 1'b0};
        vecs[19] = '{3, 12'd790, 12'd0,   1'b0, 1'b0, 12'h00A, 12'h00A, 1'b0};
        vecs[20] = '{3, 12'd810, 12'd0,   1'b1, 1'b0, 12'hABC, 12'h000, 1'b0};
        vecs[21] = '{3, 12'd800, 12'd10,  1'b1, 1'b0, 12'hABC, 12'h000, 1'b0};

        xpos = '0; ypos = '0; en = '0; rom_mode = 0;
        vin.vsync = 1'b0;
        set_pix(12'd5, 12'd5, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("reset_rgb", 32'(vout_m.rgb), 32'd0);
        check("reset_hsync", 32'(vout_m.hsync), 32'd0);
        check("reset_hcount", 32'(vout_m.hcount), 32'd0);
        check("reset_addr", 32'(addr_m), 32'd0);
        repeat (2) step();
        rst = 1'b0;

        cur_cfg = -1;
        for (int v = 0; v < 22; v++) begin
            if (vecs[v].cfg != cur_cfg) begin
                cur_cfg = vecs[v].cfg;
                load_cfg(cur_cfg);
            end
            set_pix(vecs[v].hc, vecs[v].vc, vecs[v].hb, vecs[v].vb, 1'b0);
            repeat (6) step();
            check($sformatf("vec%0d_rgb", v), 32'(vout_m.rgb), 32'(vecs[v].exp_rgb));
            check($sformatf("vec%0d_addr", v), 32'(addr_m[0]), 32'(vecs[v].exp_addr));
            if (vecs[v].sweep) begin
                check($sformatf("vec%0d_rgb_lat0", v), 32'(vout_a.rgb), 32'(vecs[v].exp_rgb));
                check($sformatf("vec%0d_rgb_lat3", v), 32'(vout_b.rgb), 32'(vecs[v].exp_rgb));
            end
        end

        // Exact latency and pixel-exact scenario in every configuration
        load_cfg(0);
        pulse_pix("px_100_200", 12'd100, 12'd200, 12'h000, 12'h000);
        pulse_pix("px_147_263", 12'd147, 12'd263, 12'hBFF, 12'hBFF);
        pulse_pix("px_148_200", 12'd148, 12'd200, 12'hABC, 12'h000);

        // Frame latch: mid-frame position change waits for the next vsync rise
        xpos[0] = 12'd400;
        hold_check_rgb("latch_old_pos", 12'd100, 12'd200, 12'h000);
        hold_check_rgb("latch_new_pos_early", 12'd400, 12'd200, 12'hABC);
        frame_start();
        hold_check_rgb("latch_new_pos", 12'd400, 12'd200, 12'h000);
        hold_check_rgb("latch_old_pos_gone", 12'd100, 12'd200, 12'hABC);

        // Values present in the vsync-edge cycle are the ones captured
        vin.vsync = 1'b1;
        xpos[0] = 12'd500;
        step();
        vin.vsync = 1'b0;
        xpos[0] = 12'd600;
        step();
        hold_check_rgb("edge_capture_500", 12'd500, 12'd200, 12'h000);
        hold_check_rgb("edge_capture_600", 12'd600, 12'd200, 12'hABC);

        // Async reset mid-line, then sprites hidden until the next vsync rise
        load_cfg(0);
        set_pix(12'd101, 12'd200, 1'b0, 1'b0, 1'b1);
        repeat (6) step();
        check("pre_rst_rgb", 32'(vout_m.rgb), 32'h001);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rgb", 32'(vout_m.rgb), 32'd0);
        check("async_rst_hsync", 32'(vout_m.hsync), 32'd0);
        check("async_rst_hcount", 32'(vout_m.hcount), 32'd0);
        check("async_rst_vcount", 32'(vout_m.vcount), 32'd0);
        check("async_rst_addr", 32'(addr_m[0]), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xpos[i] = 12'd100;
            ypos[i] = 12'd200;
        end
        en = 8'hFF;
        repeat (6) step();
        check("post_rst_hidden_rgb", 32'(vout_m.rgb), 32'hABC);
        check("post_rst_hsync", 32'(vout_m.hsync), 32'd1);
        check("post_rst_hidden_addr", 32'(addr_m[0]), 32'd0);
        frame_start();
        set_pix(12'd101, 12'd200, 1'b0, 1'b0, 1'b1);
        repeat (6) step();
        check("post_vsync_shown", 32'(vout_m.rgb), 32'h001);
        check("post_vsync_shown_lat3", 32'(vout_b.rgb), 32'h001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/draw_sprite_mux.md
# draw_sprite_mux

Parametrised multi-sprite compositor for the 800x600 @ 40 MHz VGA pipeline: the next generation of the single-image `draw_rect` stage. It overlays up to `N_SPR` ROM-backed sprites onto the incoming `vga_if` stream, with fixed index priority and colour-key transparency. Sprite positions and enables are latched only at frame start, so moving sprites never tear. It compensates a configurable ROM read latency and sits between the character overlay and `draw_mouse`.

## Interface
- `N_SPR`, 4: number of sprite channels (1..8).
- `SPR_W`, 48: sprite width in pixels.
- `SPR_H`, 64: sprite height in pixels.
- `ADDR_W`, 12: ROM address width. Requires SPR_W*SPR_H <= 2**ADDR_W (elaboration-time assertion).
- `ROM_LAT`, 1: ROM read latency in clk cycles (0..3).
- `KEY_RGB`, 12'hF0F: transparent colour.

- `clk`  input  1  pixel clock, 40 MHz.
- `rst`  input  1  asynchronous, active-high reset.
- `in`  vga_if  —  input timing plus rgb stream (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb).
- `out`  vga_if  —  delayed timing plus composited rgb.
- `spr_xpos`  input  N_SPR x 12  sprite top-left x.
- `spr_ypos`  input  N_SPR x 12  sprite top-left y.
- `spr_en`  input  N_SPR  sprite enable.
- `pixel_addr`  output  N_SPR x ADDR_W  per-sprite ROM address.
- `rgb_pixel`  input  N_SPR x 12  per-sprite ROM data, returned ROM_LAT cycles after the address.

## Operation
- **Shadow registers.**
  - On the cycle when `in.vsync` goes 0->1 (detected with a registered copy of vsync), capture `spr_xpos`, `spr_ypos` and `spr_en` into the shadow registers.
  - All hit logic uses only the shadow values.
  - Reset: shadows = 0, all disabled, vsync_d = 0.
- **Hit test, sprite i.**
  - Condition: `en_s[i]`, and not (hblnk or vblnk), and x_s <= hcount <= x_s+SPR_W-1, and y_s <= vcount <= y_s+SPR_H-1.
  - Compare in 13-bit arithmetic so a sprite at x_s = 4090 never wraps to hcount 0.
- **Address.**
  - Stage 1 register: `pixel_addr[i]` = (vcount-y_s)*SPR_W + (hcount-x_s), truncated to ADDR_W.
  - Register 0 when there is no hit.
  - Register `hit1[i]` alongside it.
- **Alignment.** `hit` is delayed a further ROM_LAT cycles, giving `hitR[i]`. It arrives at the same time as `rgb_pixel[i]`.
- **Compose stage.** The winner is the lowest index i with `hitR[i]` and `rgb_pixel[i] != KEY_RGB`.
  - `out.rgb` = the winner's `rgb_pixel`.
  - If there is no winner, `out.rgb` = the delayed `in.rgb`.
- **Pass-through.** vcount, hcount, vsync, hsync, vblnk, hblnk and rgb run through a delay line of length L = ROM_LAT+2, unmodified.
- **Reset mid-frame.**
  - All delay-line and output registers clear to 0 immediately.
  - Shadows clear, so no sprite is drawn until the next vsync rising edge after reset release.

## Timing
- Latency is L = ROM_LAT+2 cycles: `out` at cycle t+L corresponds to `in` at cycle t.
- `pixel_addr` for the pixel presented at t is valid at t+1. `rgb_pixel` for it is sampled at t+1+ROM_LAT.
- Reset values: every `out` field = 0, every `pixel_addr` = 0.
- Shadow update occurs in the same cycle as the vsync edge is seen. Pixels entering at or after t_edge+1 use the new values.
- If `spr_*` change in the same cycle as the vsync edge, those same-cycle values are captured.
- No handshake: one pixel per clk, always.

## Test plan
- **Single sprite, ROM_LAT=1.** Sprite 0 at (100,200), enabled, ROM returns addr[11:0] as rgb.
  - Pixel (100,200) -> out.rgb = 12'h000, 3 cycles later.
  - Pixel (147,263) -> addr 3071 = 12'hBFF.
  - Pixel (148,200) -> background rgb.
- **Priority and key.** Sprites 0 and 1 both at (300,300). ROM0 returns KEY_RGB on even addresses and 12'h111 otherwise; ROM1 returns 12'h222.
  - Output alternates 12'h222 / 12'h111 along the row.
- **Frame latch.** Change spr_xpos[0] from 100 to 400 mid-frame.
  - The rest of the frame is still drawn at x = 100.
  - The frame after the vsync rise is drawn at x = 400.
- **Wrap and blanking.**
  - Sprite at x = 4090: no hit on any visible pixel, pixel_addr stays 0.
  - A sprite overlapping the hblnk region: output rgb = the delayed input rgb, never sprite data.
- **Async reset.** Assert rst mid-line with no clk edge.
  - out.* = 0 at once.
  - After release, sprites stay hidden until the next vsync rise, even with spr_en = all 1.
- **Parameter sweep.** ROM_LAT = 0 and ROM_LAT = 3, N_SPR = 1 and N_SPR = 8.
  - Latency = ROM_LAT+2 measured on hsync.
  - The pixel-exact scenario-1 result is repeated in each configuration.
